// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frames input samples into N-point FFT frames, injects zero flush frames
// when the stream idles, and tags/labels pipeline results by frame.
module fft_frame_ctrl #(
  parameter int N         = 32,
  parameter int IDLE_GAP  = 4,
  parameter int TAG_DEPTH = 4,
  parameter int RW        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [10:0]      in_r,
  input  logic signed [10:0]      in_i,
  input  logic                    flush_req,
  output logic                    pipe_valid,
  output logic signed [10:0]      pipe_r,
  output logic signed [10:0]      pipe_i,
  input  logic                    res_valid,
  input  logic signed [RW-1:0]    res_r,
  input  logic signed [RW-1:0]    res_i,
  output logic                    out_valid,
  output logic signed [RW-1:0]    out_r,
  output logic signed [RW-1:0]    out_i,
  output logic [$clog2(N)-1:0]    out_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err
);
  localparam int LN = $clog2(N);
  localparam int TW = $clog2(TAG_DEPTH);
  localparam int GW = $clog2(IDLE_GAP + 1);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;
  state_t state_q, state_d;
  logic [LN-1:0] cnt_q, cnt_d, ocnt_q, rev;
  logic [GW-1:0] idle_q, idle_d;
  logic pend_q, pend_d, alive_q;
  logic [TAG_DEPTH-1:0] tags_q;
  logic [TW-1:0] wp_q, rp_q;
  logic [TW:0] tcnt_q;
  logic pipe_valid_q, out_valid_q, out_last_q, err_q;
  logic signed [10:0] pipe_r_q, pipe_i_q;
  logic signed [RW-1:0] out_r_q, out_i_q;
  logic [LN-1:0] out_idx_q;
  logic full, acc, tail_real, go_flush, flush_end, push, have, take, pop;
  assign full      = tcnt_q == (TW+1)'(TAG_DEPTH);
  assign in_ready  = alive_q && state_q != FLUSH && !(state_q == IDLE && full);
  assign acc       = in_valid && in_ready;
  // the newest queued tag being REAL means a real frame still needs draining
  assign tail_real = tcnt_q != '0 && tags_q[wp_q - 1'b1];
  assign go_flush  = state_q == IDLE && !acc && (idle_q == GW'(IDLE_GAP) || pend_q || flush_req)
                     && tail_real && !full;
  assign flush_end = state_q == FLUSH && cnt_q == LN'(N - 1);
  assign push      = (state_q == IDLE && acc) || go_flush;
  assign have      = tcnt_q != '0;
  assign take      = res_valid && have;
  assign pop       = take && ocnt_q == LN'(N - 1);
  always_comb begin
    state_d = go_flush ? FLUSH : (flush_end || (acc && cnt_q == LN'(N - 1))) ? IDLE : acc ? LOAD : state_q;
    cnt_d   = (acc || state_q == FLUSH) ? cnt_q + 1'b1 : cnt_q;
    idle_d  = (acc || flush_end) ? '0 :
              (state_q == IDLE && !in_valid && idle_q != GW'(IDLE_GAP)) ? idle_q + 1'b1 : idle_q;
    pend_d  = go_flush ? 1'b0 : pend_q | flush_req;
    rev     = '0;
    for (int b = 0; b < LN; b++) rev[b] = ocnt_q[LN-1-b];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idle_q       <= '0;
      pend_q       <= 1'b0;
      alive_q      <= 1'b0;
      tags_q       <= '0;
      wp_q         <= '0;
      rp_q         <= '0;
      tcnt_q       <= '0;
      ocnt_q       <= '0;
      pipe_valid_q <= 1'b0;
      pipe_r_q     <= '0;
      pipe_i_q     <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_idx_q    <= '0;
      out_r_q      <= '0;
      out_i_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idle_q       <= idle_d;
      pend_q       <= pend_d;
      alive_q      <= 1'b1;
      pipe_valid_q <= acc || state_q == FLUSH;
      pipe_r_q     <= acc ? in_r : '0;
      pipe_i_q     <= acc ? in_i : '0;
      if (push) begin
        tags_q[wp_q] <= !go_flush;
        wp_q         <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      tcnt_q      <= tcnt_q + (TW+1)'(push) - (TW+1)'(pop);
      out_valid_q <= take && tags_q[rp_q];
      out_last_q  <= take && tags_q[rp_q] && ocnt_q == LN'(N - 1);
      if (take) begin
        ocnt_q    <= ocnt_q + 1'b1;
        out_idx_q <= rev;
        out_r_q   <= res_r;
        out_i_q   <= res_i;
      end
      if (res_valid && !have) err_q <= 1'b1;
    end
  end
  assign pipe_valid = pipe_valid_q;
  assign pipe_r     = pipe_r_q;
  assign pipe_i     = pipe_i_q;
  assign out_valid  = out_valid_q;
  assign out_r      = out_r_q;
  assign out_i      = out_i_q;
  assign out_idx    = out_idx_q;
  assign out_last   = out_last_q;
  assign busy       = state_q != IDLE || tcnt_q != '0;
  assign err        = err_q;
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed vectors and table-driven result checks for fft_frame_ctrl.
module tb_fft_frame_ctrl;
  logic clk = 0, rst_n = 0, in_valid = 0, flush_req = 0, res_valid = 0;
  logic signed [10:0] in_r = 0, in_i = 0;
  logic signed [15:0] res_r = 0, res_i = 0;
  logic in_ready, pipe_valid, out_valid, out_last, busy, err;
  logic signed [10:0] pipe_r, pipe_i;
  logic signed [15:0] out_r, out_i;
  logic [4:0] out_idx;
  int nchk = 0, nerr = 0;

  typedef struct {
    logic rv;
    logic [15:0] r;
    logic [15:0] i;
    logic ev;
    logic el;
    logic [4:0] idx;
  } vec_t;
  vec_t tbl[80];
  int nv = 0;

  fft_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_i(in_i), .flush_req(flush_req),
    .pipe_valid(pipe_valid), .pipe_r(pipe_r), .pipe_i(pipe_i),
    .res_valid(res_valid), .res_r(res_r), .res_i(res_i),
    .out_valid(out_valid), .out_r(out_r), .out_i(out_i),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [4:0] bitrev5(input logic [4:0] k);
    return {k[0], k[1], k[2], k[3], k[4]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0; in_valid = 0; flush_req = 0; res_valid = 0;
    in_r = 0; in_i = 0; res_r = 0; res_i = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    step;
  endtask

  task automatic feed(input int n, input int base, input int req_at, output int bad);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      if (!in_ready) bad++;
      in_valid = 1; in_r = 11'(base + k); in_i = 11'(-(base + k)); flush_req = (k == req_at);
      step;
      if (!pipe_valid || pipe_r != 11'(base + k) || pipe_i != 11'(-(base + k))) bad++;
    end
    in_valid = 0; flush_req = 0;
  endtask

  // lead quiet pipe cycles, then exactly 32 zero samples with in_ready held low, then quiet
  task automatic flush_window(input int lead, output int bad);
    bad = 0;
    for (int k = 0; k < lead; k++) begin
      step;
      if (pipe_valid) bad++;
    end
    for (int k = 0; k < 32; k++) begin
      step;
      if (!pipe_valid || pipe_r != 0 || pipe_i != 0) bad++;
      if (k < 31 && in_ready) bad++;
    end
    step;
    if (pipe_valid) bad++;
  endtask

  initial begin
    int bad, b2, cv, cl;
    for (int k = 0; k < 32; k++) begin
      if (k == 10) begin
        tbl[nv] = '{rv: 0, r: 0, i: 0, ev: 0, el: 0, idx: 0}; nv++;
      end
      tbl[nv] = '{rv: 1, r: 16'(1000 + k), i: 16'(k * 7), ev: 1, el: (k == 31), idx: bitrev5(5'(k))}; nv++;
    end
    tbl[nv] = '{rv: 0, r: 0, i: 0, ev: 0, el: 0, idx: 0}; nv++;
    for (int k = 0; k < 32; k++) begin
      tbl[nv] = '{rv: 1, r: 16'(500 + k), i: 16'(3), ev: 0, el: 0, idx: 0}; nv++;
    end

    @(posedge clk); #1;
    chk("rst_ctrl", {in_ready, pipe_valid, out_valid, out_last, busy, err}, 0);
    chk("rst_data", {pipe_r, pipe_i, out_r, out_i, out_idx}, 0);

    // single frame, automatic flush after the idle gap, then results
    do_reset;
    chk("t1_ready", in_ready, 1);
    chk("t1_busy_idle", busy, 0);
    feed(32, 1, -1, bad);
    chk("t1_feed", bad, 0);
    chk("t1_busy_load", busy, 1);
    flush_window(5, bad);
    chk("t1_flush", bad, 0);
    chk("t1_busy_tags", busy, 1);
    for (int v = 0; v < nv; v++) begin
      res_valid = tbl[v].rv; res_r = tbl[v].r; res_i = tbl[v].i;
      step;
      chk($sformatf("t1_res[%0d]", v),
          {out_valid, out_valid ? {out_last, out_idx, out_r, out_i} : 38'd0},
          {tbl[v].ev, tbl[v].ev ? {tbl[v].el, tbl[v].idx, tbl[v].r, tbl[v].i} : 38'd0});
    end
    res_valid = 0;
    chk("t1_busy_done", busy, 0);
    chk("t1_err_clear", err, 0);
    res_valid = 1; res_r = 16'(9);
    step;
    res_valid = 0;
    chk("t1_err_drop", out_valid, 0);
    chk("t1_err_set", err, 1);
    step;
    chk("t1_err_sticky", err, 1);

    // three back-to-back frames, single trailing flush
    do_reset;
    feed(96, 1, -1, bad);
    chk("t2_feed", bad, 0);
    flush_window(5, bad);
    chk("t2_flush", bad, 0);
    cv = 0; cl = 0; bad = 0;
    for (int k = 0; k < 128; k++) begin
      res_valid = 1; res_r = 16'(k); res_i = 0;
      step;
      if (out_valid) cv++;
      if (out_valid && out_last) cl++;
      if (out_valid && out_idx != bitrev5(5'(k))) bad++;
    end
    res_valid = 0;
    chk("t2_beats", cv, 96);
    chk("t2_lasts", cl, 3);
    chk("t2_idx", bad, 0);
    chk("t2_busy", busy, 0);

    // two-cycle gap inside a frame
    do_reset;
    feed(9, 1, -1, bad);
    b2 = 0;
    for (int k = 0; k < 2; k++) begin
      step;
      if (pipe_valid || !in_ready) b2++;
    end
    feed(23, 10, -1, cv);
    chk("t3_pipe_pattern", bad + b2 + cv, 0);
    flush_req = 1;
    step;
    flush_req = 0;
    chk("t3_frame_done", pipe_valid, 0);
    step;
    chk("t3_flush_start", {pipe_valid, pipe_r}, {1'b1, 11'd0});

    // tag FIFO full blocks the fifth frame until one result frame drains
    do_reset;
    feed(128, 1, -1, bad);
    chk("t4_feed", bad, 0);
    in_valid = 1; in_r = 11'(200); in_i = 11'(-200);
    chk("t4_ready_full", in_ready, 0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      step;
      if (in_ready || pipe_valid) bad++;
    end
    chk("t4_blocked", bad, 0);
    bad = 0; cv = 0;
    for (int k = 0; k < 32; k++) begin
      res_valid = 1; res_r = 16'(k); res_i = 0;
      step;
      if (k < 31 && in_ready) bad++;
      if (out_valid) cv++;
    end
    res_valid = 0;
    chk("t4_hold_during_drain", bad, 0);
    chk("t4_drain_beats", cv, 32);
    chk("t4_ready_after_pop", in_ready, 1);
    step;
    in_valid = 0;
    chk("t4_accept", {pipe_valid, pipe_r}, {1'b1, 11'd200});

    // sample arriving as the idle count reaches the gap wins over flush
    do_reset;
    feed(32, 1, -1, bad);
    for (int k = 0; k < 4; k++) begin
      step;
      if (pipe_valid) bad++;
    end
    in_valid = 1; in_r = 11'(77); in_i = 11'(5);
    step;
    in_valid = 0;
    chk("t5_race_quiet", bad, 0);
    chk("t5_race_accept", {pipe_valid, pipe_r, pipe_i}, {1'b1, 11'd77, 11'd5});
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      step;
      if (pipe_valid || !in_ready) bad++;
    end
    chk("t5_race_no_flush", bad, 0);

    // flush_req mid-frame takes effect right after the frame's last sample
    do_reset;
    feed(32, 1, 19, bad);
    chk("t5_req_feed", bad, 0);
    flush_window(1, bad);
    chk("t5_req_flush", bad, 0);

    // reset mid-frame discards the partial frame
    do_reset;
    res_valid = 1;
    step;
    res_valid = 0;
    chk("t6_err", {err, out_valid}, {1'b1, 1'b0});
    feed(15, 1, -1, bad);
    chk("t6_feed", bad, 0);
    in_valid = 1; in_r = 11'(50); in_i = 11'(50);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_ctrl", {in_ready, pipe_valid, out_valid, out_last, busy, err}, 0);
    chk("t6_rst_data", {pipe_r, pipe_i, out_r, out_i, out_idx}, 0);
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (pipe_valid || in_ready) bad++;
    end
    chk("t6_rst_hold", bad, 0);
    in_valid = 0;
    rst_n = 1;
    step;
    chk("t6_release", {in_ready, busy, err}, {1'b1, 1'b0, 1'b0});
    feed(32, 1, -1, bad);
    chk("t6_refeed", bad, 0);
    flush_req = 1;
    step;
    flush_req = 0;
    chk("t6_frame_done", pipe_valid, 0);
    step;
    chk("t6_flush_start", {pipe_valid, pipe_r}, {1'b1, 11'd0});

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer that sits in front of the 32-point SDF FFT pipeline; the pipeline's first stage takes 11-bit complex samples with a valid strobe. It takes samples from upstream on a valid/ready handshake and counts them into 32-sample frames. When the input stream goes quiet, it injects zero-valued flush frames so the delay-feedback stages drain. On the result side it tags each output frame as real or flush, suppresses flush results, and labels each real result with its natural-order bin index (output is bit-reversed) plus a last-of-frame marker.

## Interface

- N, 32, FFT length; must be a power of two; frame counter width log2(N).
- IDLE_GAP, 4, number of consecutive idle cycles at a frame boundary before a flush frame starts.
- TAG_DEPTH, 4, depth of the real/flush tag FIFO (frames in flight).
- RW, 16, result sample width.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  controller accepts a sample when in_valid && in_ready.
- in_r, in_i  in  11 each  signed sample.
- flush_req  in  1  single-cycle request to force a flush at the next frame boundary.
- pipe_valid  out  1  sample strobe into the pipeline.
- pipe_r, pipe_i  out  11 each  sample into the pipeline.
- res_valid  in  1  result strobe from the pipeline's last stage.
- res_r, res_i  in  RW each  result sample.
- out_valid  out  1  real result valid.
- out_r, out_i  out  RW each  result sample.
- out_idx  out  log2(N)  natural-order bin index of the result.
- out_last  out  1  high with the final result of a frame.
- busy  out  1  high if a frame is loading or flushing, or any tag is outstanding.
- err  out  1  sticky; set when res_valid arrives while the tag FIFO is empty; cleared only by reset.

## Operation

- States:
  - IDLE: input counter = 0, no partial frame.
  - LOAD: 0 < counter < N.
  - FLUSH: zero frame being injected.
- IDLE → LOAD: on an accepted sample.
  - That sample pushes tag REAL.
  - The counter becomes 1.
- LOAD: each accepted sample increments the counter.
  - Gaps (in_valid low) are allowed; pipe_valid is low during a gap.
  - On acceptance of sample N-1, the counter wraps to 0 and the state returns to IDLE.
- IDLE → FLUSH: requires all of the following:
  - (idle counter reaches IDLE_GAP, or flush_req is pending);
  - at least one REAL tag is younger than the newest FLUSH tag (or no FLUSH tag is queued);
  - the tag FIFO is not full.
  - Entry pushes tag FLUSH.
- FLUSH lasts exactly N cycles.
  - pipe_valid = 1 and pipe_r = pipe_i = 0 every cycle.
  - in_ready = 0 throughout.
  - Then the state returns to IDLE and the idle counter clears.
- Idle counter: increments in IDLE while in_valid is low, saturating at IDLE_GAP; clears on any accept.
- flush_req:
  - Latched into a pending bit.
  - Cleared when FLUSH is entered.
  - If it arrives in LOAD, the current frame completes first.
- in_ready = (state != FLUSH) && !(state == IDLE && tag FIFO full).
  - A frame that has started is never blocked mid-frame.
- Simultaneous in_valid and flush condition in IDLE: the sample wins; a new frame starts and no flush occurs.
- Result side:
  - The output counter increments on each res_valid.
  - out_idx = bit-reverse(output counter).
  - out_last = (output counter == N-1).
  - At N-1 the counter wraps and the head tag pops.
  - out_valid = res_valid && head tag == REAL; res data passes through unmodified.
- res_valid with the tag FIFO empty:
  - err is set.
  - The result is dropped and the output counter does not advance.
- A tag push and a tag pop in the same cycle are both performed; occupancy is unchanged.

## Timing

- Input path is registered: pipe_valid/pipe_r/pipe_i appear one cycle after the accepting edge.
- Output path is registered: out_* appear one cycle after res_valid.
- in_ready is a combinational decode of registered state; it has no path from in_valid.
- Reset values: all of the following are 0, with the tag FIFO empty and the counters at 0:
  - in_ready, pipe_valid, pipe_r, pipe_i;
  - out_valid, out_r, out_i, out_idx, out_last;
  - busy, err.
- First cycle after reset release: in_ready = 1, state = IDLE.
- Reset mid-frame or mid-flush:
  - All state is discarded and the partial frame is lost.
  - No pipe_valid is issued after assertion.
- Flush frame: occupies N consecutive pipe_valid cycles starting one cycle after FLUSH entry.

## Test plan

- Single frame: 32 samples, values 1..32 back-to-back, then in_valid low. Required response:
  - pipe_valid high for 32 cycles.
  - After 4 idle cycles, 32 zero pipe cycles.
  - 32 out_valid beats with out_idx 0,16,8,24,…,31 and out_last on the 32nd.
  - The flush-frame results are suppressed; busy falls to 0 afterwards.
- Back-to-back frames: 3 frames with no gaps → no flush between frames; 96 out_valid beats; exactly one flush after frame 3.
- Gapped input: in_valid low for 2 cycles at sample 10 → pipe_valid has a 2-cycle hole; no flush starts; frame completes at sample 32.
- Tag full: hold res_valid low, feed 4 frames → in_ready = 0 at the boundary of the 5th frame; one res frame drained → in_ready = 1 on the next cycle.
- Boundary race: in_valid rises on the cycle the idle counter hits IDLE_GAP → the sample is accepted and no FLUSH occurs. Separately, flush_req at sample 20 → FLUSH starts immediately after sample 32.
- Errors and reset: res_valid with tags empty → err = 1, out_valid = 0; rst_n low at sample 15 → all outputs 0 and in_ready = 1 after release.
